alu_stim_checker: RTL and testbench
===================================

Name: alu_stim_checker

Overview:
- Self-checking stimulus stage directly downstream of the simulation clock/reset generator.
- Consumes `clk`/`reset` and drives pseudo-random operand/opcode vectors into the ALU under test over a valid/ready handshake.
- Captures each ALU result, compares it against an internal reference model, and reports pass/fail counts plus `done`/`timeout` status for the bench to sample before `$finish`.

Parameters:
- WIDTH, 8: ALU operand/result width; legal range 4..16.
- NUM_VECTORS, 16: vectors issued before `done`.
- RESP_TIMEOUT, 32: max cycles in WAIT before the vector is declared lost.
- MAX_CYCLES, 10000: global watchdog, counted in cycles after reset release.
- SEED, 16'h0001: LFSR seed; a value of 0 is replaced by 16'hACE1.
- CNT_W, 16: width of the counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- alu_a  out  WIDTH  operand A
- alu_b  out  WIDTH  operand B
- alu_op  out  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SHL, 7 SHR
- alu_valid  out  1  vector offered
- alu_ready  in  1  ALU accepts vector
- alu_result  in  WIDTH  ALU result
- alu_result_valid  in  1  result strobe, one cycle per accepted vector
- pass_count  out  CNT_W  matching results
- fail_count  out  CNT_W  mismatches + spurious strobes + timeouts
- first_fail_idx  out  CNT_W  index of first failing vector; all-ones if none
- done  out  1  sticky, run finished
- timeout  out  1  sticky, response or global watchdog fired

Behaviour:
- Reset (`reset`=0, async):
  - State -> IDLE, LFSR -> SEED, vector index -> 0, all counters -> 0.
  - Outputs: `alu_valid`=0, `alu_a`/`alu_b`/`alu_op`=0, `done`=0, `timeout`=0, `first_fail_idx`=all-ones.
  - Assertion mid-run aborts immediately; `alu_valid` drops combinationally with reset.
- FSM states: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE -> ISSUE on the first clock edge after reset release.
- ISSUE:
  - `alu_valid`=1; `alu_a`=lfsr[WIDTH-1:0], `alu_b`=lfsr[15:16-WIDTH], `alu_op`=index[2:0].
  - Operands held stable until `alu_valid`&&`alu_ready`.
  - On handshake: latch expected result, deassert `alu_valid` next cycle, -> WAIT.
- WAIT:
  - On `alu_result_valid`: capture `alu_result`, -> CHECK.
  - If the per-vector cycle counter reaches RESP_TIMEOUT: `fail_count`+1, `timeout`=1, record `first_fail_idx` if unset, -> DONE.
- CHECK (one cycle):
  - Match: `pass_count`+1. Mismatch: `fail_count`+1 and record `first_fail_idx` if unset.
  - LFSR advances one step; index+1.
  - If the new index == NUM_VECTORS -> DONE, else -> ISSUE.
- LFSR: 16-bit Fibonacci, shift left, new bit0 = l[15]^l[13]^l[12]^l[10].
- Reference model:
  - ADD/SUB modulo 2^WIDTH; AND/OR/XOR bitwise.
  - SLT: signed compare, result 1 or 0, zero-extended.
  - SHL/SHR: logical shift by b[$clog2(WIDTH)-1:0].
- ALU latency must be >=1 cycle. An `alu_result_valid` seen in IDLE, ISSUE or CHECK is spurious: `fail_count`+1, no state change.
- Global watchdog: cycle counter reaching MAX_CYCLES in any non-DONE state -> `timeout`=1, -> DONE.
- DONE: `done`=1, `alu_valid`=0, counters frozen; only reset leaves DONE.
- Counters saturate at all-ones.
- Simultaneous events: a CHECK-cycle spurious strobe and a mismatch in the same cycle add 2 to `fail_count`; the watchdog has priority over all other transitions.

Optional Feature:
- Macro: ALU_STIM_STOP_ON_FAIL_EN.
- Defined: the first mismatch or spurious strobe moves the FSM to DONE on the next edge, with no further vectors issued.
- Undefined: failures are counted and the run continues through NUM_VECTORS.

Test Plan:
- Ideal ALU model with 1-cycle latency, `alu_ready`=1, SEED=1, WIDTH=8 -> first vector a=0x01, b=0x00, op=0, expected 0x01; `done`=1 at cycle 49 after reset release; `pass_count`=16, `fail_count`=0, `first_fail_idx`=0xFFFF.
- ALU model with op 1 (SUB) inverted -> `fail_count`=2 (indices 1 and 9), `pass_count`=14, `first_fail_idx`=1. With ALU_STIM_STOP_ON_FAIL_EN: `fail_count`=1, `done` asserted after vector 1.
- `alu_ready` held low 5 cycles on vector 0 -> `alu_a`/`alu_b`/`alu_op` stable across all 5 cycles, single handshake, final counts unchanged.
- ALU never strobes `alu_result_valid` -> after 32 cycles in WAIT: `timeout`=1, `fail_count`=1, `first_fail_idx`=0, `done`=1.
- Reset pulsed low while in WAIT on vector 3 -> `alu_valid`=0 immediately, counters 0; after release the run restarts at vector 0 with LFSR=SEED.
- Extra `alu_result_valid` pulse during ISSUE -> `fail_count`+1, vector sequence unaffected.

Source files
------------

// File: rtl/alu_stim_checker.sv
// Self-checking ALU stimulus stage: LFSR-driven vectors over valid/ready, reference-model compare.
// Optional `ALU_STIM_STOP_ON_FAIL_EN: first mismatch or spurious strobe ends the run.
module alu_stim_checker #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_VECTORS  = 16,
  parameter int unsigned RESP_TIMEOUT = 32,
  parameter int unsigned MAX_CYCLES   = 10000,
  parameter logic [15:0] SEED         = 16'h0001,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_valid,
  input  logic             alu_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_result_valid,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned ShW     = $clog2(WIDTH);
  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [CNT_W-1:0] NumVec  = CNT_W'(NUM_VECTORS);
  localparam logic [31:0]      WaitLim = 32'(RESP_TIMEOUT - 1);
  localparam logic [31:0]      CycLim  = 32'(MAX_CYCLES - 1);
`ifdef ALU_STIM_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] idx_q, idx_d, pass_q, pass_d, fail_q, fail_d, ffi_q, ffi_d;
  logic [WIDTH-1:0] exp_q, exp_d, res_q, res_d;
  logic [31:0]      wait_q, wait_d, cyc_q, cyc_d;
  logic             to_q, to_d;
  logic [1:0]       fail_inc;
  logic             stop, hs, spurious, wdog;
  logic [WIDTH-1:0] op_a, op_b;

  function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0] op);
    logic [WIDTH-1:0] r;
    unique case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      3'd6:    r = a << b[ShW-1:0];
      default: r = a >> b[ShW-1:0];
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign op_a      = lfsr_q[WIDTH-1:0];
  assign op_b      = lfsr_q[15:16-WIDTH];
  // Gated with reset so the offer disappears the instant reset asserts.
  assign alu_valid = (state_q == StIssue) && reset;
  assign alu_a     = (state_q == StIssue) ? op_a : '0;
  assign alu_b     = (state_q == StIssue) ? op_b : '0;
  assign alu_op    = (state_q == StIssue) ? idx_q[2:0] : 3'd0;
  assign hs        = alu_valid && alu_ready;
  assign spurious  = alu_result_valid &&
                     ((state_q == StIdle) || (state_q == StIssue) || (state_q == StCheck));
  assign wdog      = (state_q != StDone) && (cyc_q >= CycLim);

  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_idx = ffi_q;
  assign done           = (state_q == StDone);
  assign timeout        = to_q;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    ffi_d    = ffi_q;
    exp_d    = exp_q;
    res_d    = res_q;
    wait_d   = wait_q;
    to_d     = to_q;
    fail_inc = 2'd0;
    stop     = 1'b0;
    cyc_d    = (state_q != StDone && cyc_q != '1) ? cyc_q + 32'd1 : cyc_q;

    if (spurious) begin
      fail_inc = 2'd1;
      stop     = 1'b1;
    end

    unique case (state_q)
      StIdle: state_d = StIssue;
      StIssue: begin
        if (hs) begin
          exp_d   = ref_model(op_a, op_b, idx_q[2:0]);
          wait_d  = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (alu_result_valid) begin
          res_d   = alu_result;
          state_d = StCheck;
        end else if (wait_q >= WaitLim) begin
          fail_inc = 2'd1;
          to_d     = 1'b1;
          if (ffi_q == '1) ffi_d = idx_q;
          state_d  = StDone;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      StCheck: begin
        if (res_q == exp_q) begin
          pass_d = sat_add(pass_q, 2'd1);
        end else begin
          fail_inc = fail_inc + 2'd1;
          stop     = 1'b1;
          if (ffi_q == '1) ffi_d = idx_q;
        end
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == NumVec) ? StDone : StIssue;
      end
      default: state_d = StDone;
    endcase

    fail_d = sat_add(fail_q, fail_inc);
    if (StopOnFail && stop) state_d = StDone;
    if (wdog) begin
      to_d    = 1'b1;
      state_d = StDone;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      lfsr_q  <= SeedEff;
      idx_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '1;
      exp_q   <= '0;
      res_q   <= '0;
      wait_q  <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_alu_stim_checker.sv
// Table-driven bench for alu_stim_checker: a behavioural ALU responds to each vector,
// and a local LFSR model predicts every operand pair the checker offers.
module tb_alu_stim_checker;

  localparam int ModeIdeal  = 0;
  localparam int ModeSubInv = 1;
  localparam int ModeNoResp = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_valid, alu_ready, alu_result_valid;
  logic [15:0] pass_count, fail_count, first_fail_idx;
  logic        done, timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_stim_checker dut (
    .clk             (clk),
    .reset           (reset),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_op          (alu_op),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_result      (alu_result),
    .alu_result_valid(alu_result_valid),
    .pass_count      (pass_count),
    .fail_count      (fail_count),
    .first_fail_idx  (first_fail_idx),
    .done            (done),
    .timeout         (timeout)
  );

  typedef struct {
    int          mode;
    int          stall;
    bit          spur;
    bit          rst_mid;
    int          exp_pass;
    int          exp_fail;
    bit          chk_ffi;
    logic [15:0] exp_ffi;
    bit          exp_to;
    int          exp_hs;
    int          exp_done_cyc;
  } scen_t;

  scen_t tbl[6];

  task automatic chk(input int s, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL s%0d %s: got %0h expected %0h", s, name, act, exp);
    end
  endtask

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      3'd6:    return a << b[2:0];
      default: return a >> b[2:0];
    endcase
  endfunction

  task automatic run_scen(input int s);
    scen_t       sc;
    logic [15:0] m_lfsr;
    logic [7:0]  pend_res, h_a, h_b;
    logic [2:0]  h_op;
    int          vec, cyc, hs_cnt, done_cyc, stall_left;
    bit          pend, spur_done, rst_done;
    sc = tbl[s];

    reset = 1'b0;
    alu_ready = 1'b1;
    alu_result_valid = 1'b0;
    alu_result = 8'h00;
    repeat (2) @(negedge clk);
    chk(s, "rst_valid", 32'(alu_valid), 32'd0);
    chk(s, "rst_done", 32'(done), 32'd0);
    chk(s, "rst_timeout", 32'(timeout), 32'd0);
    chk(s, "rst_pass", 32'(pass_count), 32'd0);
    chk(s, "rst_fail", 32'(fail_count), 32'd0);
    chk(s, "rst_ffi", 32'(first_fail_idx), 32'hFFFF);
    chk(s, "rst_ops", {8'h0, alu_a, alu_b, 5'h0, alu_op}, 32'd0);

    reset = 1'b1;
    m_lfsr = 16'h0001;
    vec = 0; cyc = 0; hs_cnt = 0; done_cyc = -1; stall_left = sc.stall;
    pend = 1'b0; spur_done = 1'b0; rst_done = 1'b0;
    pend_res = 8'h00; h_a = 8'h00; h_b = 8'h00; h_op = 3'd0;

    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cyc = cyc;
      end else if (sc.rst_mid && !rst_done && vec == 4 && pend) begin
        // Checker is now waiting on vector 3's result.
        chk(s, "pre_rst_pass", 32'(pass_count), 32'd3);
        reset = 1'b0;
        alu_result_valid = 1'b0;
        #1;
        chk(s, "mid_rst_valid", 32'(alu_valid), 32'd0);
        chk(s, "mid_rst_pass", 32'(pass_count), 32'd0);
        chk(s, "mid_rst_fail", 32'(fail_count), 32'd0);
        chk(s, "mid_rst_ffi", 32'(first_fail_idx), 32'hFFFF);
        @(negedge clk);
        reset = 1'b1;
        rst_done = 1'b1;
        m_lfsr = 16'h0001;
        vec = 0; cyc = 0; hs_cnt = 0; pend = 1'b0;
      end else begin
        alu_result_valid = pend && (sc.mode != ModeNoResp);
        alu_result = pend_res;
        pend = 1'b0;
        alu_ready = 1'b1;
        if (sc.spur && !spur_done && vec == 2 && alu_valid) begin
          alu_result_valid = 1'b1;
          alu_ready = 1'b0;
          spur_done = 1'b1;
        end else if (vec == 0 && stall_left > 0 && alu_valid) begin
          if (stall_left == sc.stall) begin
            h_a = alu_a; h_b = alu_b; h_op = alu_op;
          end else begin
            chk(s, "stall_stable", {8'h0, alu_a, alu_b, 5'h0, alu_op},
                {8'h0, h_a, h_b, 5'h0, h_op});
          end
          alu_ready = 1'b0;
          stall_left--;
        end
        if (alu_valid && alu_ready) begin
          chk(s, "vec_a", 32'(alu_a), 32'(m_lfsr[7:0]));
          chk(s, "vec_b", 32'(alu_b), 32'(m_lfsr[15:8]));
          chk(s, "vec_op", 32'(alu_op), 32'(vec % 8));
          pend_res = alu_fn(alu_a, alu_b, alu_op);
          if (sc.mode == ModeSubInv && alu_op == 3'd1) pend_res = ~pend_res;
          pend = 1'b1;
          m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
          vec++;
          hs_cnt++;
        end
      end
    end

    chk(s, "done_reached", 32'(done), 32'd1);
    alu_result_valid = 1'b0;
    alu_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk(s, "pass", 32'(pass_count), 32'(sc.exp_pass));
    chk(s, "fail", 32'(fail_count), 32'(sc.exp_fail));
    if (sc.chk_ffi) chk(s, "ffi", 32'(first_fail_idx), 32'(sc.exp_ffi));
    chk(s, "timeout", 32'(timeout), 32'(sc.exp_to));
    chk(s, "done_sticky", 32'(done), 32'd1);
    chk(s, "done_valid", 32'(alu_valid), 32'd0);
    chk(s, "handshakes", 32'(hs_cnt), 32'(sc.exp_hs));
    chk(s, "done_cycle", 32'(done_cyc), 32'(sc.exp_done_cyc));
  endtask

  initial begin
    alu_ready = 1'b1;
    alu_result_valid = 1'b0;
    alu_result = 8'h00;
    //          mode        stl spur rst  pass fail ffi? ffi      to hs done
    tbl[0] = '{ModeIdeal,  0, 1'b0, 1'b0, 16, 0, 1'b1, 16'hFFFF, 1'b0, 16, 49};
`ifdef ALU_STIM_STOP_ON_FAIL_EN
    tbl[1] = '{ModeSubInv, 0, 1'b0, 1'b0, 1, 1, 1'b1, 16'h0001, 1'b0, 2, 7};
`else
    tbl[1] = '{ModeSubInv, 0, 1'b0, 1'b0, 14, 2, 1'b1, 16'h0001, 1'b0, 16, 49};
`endif
    tbl[2] = '{ModeIdeal,  5, 1'b0, 1'b0, 16, 0, 1'b1, 16'hFFFF, 1'b0, 16, 54};
    tbl[3] = '{ModeNoResp, 0, 1'b0, 1'b0, 0, 1, 1'b1, 16'h0000, 1'b1, 1, 34};
    tbl[4] = '{ModeIdeal,  0, 1'b0, 1'b1, 16, 0, 1'b1, 16'hFFFF, 1'b0, 16, 49};
`ifdef ALU_STIM_STOP_ON_FAIL_EN
    tbl[5] = '{ModeIdeal,  0, 1'b1, 1'b0, 2, 1, 1'b0, 16'hFFFF, 1'b0, 2, 8};
`else
    tbl[5] = '{ModeIdeal,  0, 1'b1, 1'b0, 16, 1, 1'b0, 16'hFFFF, 1'b0, 16, 50};
`endif
    for (int s = 0; s < 6; s++) run_scen(s);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
